mc_ctrl_fsm: RTL and testbench

Multicycle successor to the single-cycle main decoder. It is a Moore-style control FSM that sequences each MIPS instruction through fetch, decode, execute, memory and writeback states. It adds a variable-latency memory handshake, an illegal-opcode flag and a retired-instruction counter. It sits between the instruction register opcode field and the multicycle datapath.

---
 rtl/mc_ctrl_fsm.sv | 205 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback with a memory handshake.
// Latency: outputs are Moore decodes of the state register (FETCH and DECODE also look at mem_ready/op); next state one edge later.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0; no other state stalls.
// Optional feature macro: MC_CTRL_BNE_EN (adds BNE decode and the branch_ne output).
// Ports: clk, reset_n (sync, active-low); op, mem_ready in; datapath controls, illegal_op,
//        state (debug) and retired (completed-instruction count) out.
module mc_ctrl_fsm #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               branch,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [ALUOP_W-1:0] aluop,
    output logic [1:0]         pcsrc,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               illegal_op,
`ifdef MC_CTRL_BNE_EN
    output logic               branch_ne,
`endif
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // Opcodes compare against the full op width, so nonzero upper bits never decode.
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_RTYP = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
`ifdef MC_CTRL_BNE_EN
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b000101);
    logic bne_q;
`endif

    state_t state_q;
    state_t state_d;
    logic   ret_inc;   // this edge completes an instruction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            retired <= '0;
`ifdef MC_CTRL_BNE_EN
            bne_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (ret_inc) begin
                retired <= retired + CNT_W'(1);
            end
`ifdef MC_CTRL_BNE_EN
            // Captured on the decode edge so BRANCH sees the flavour of this instruction.
            if (state_q == S_DECODE) begin
                bne_q <= (op == OP_BNE);
            end
`endif
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        ret_inc    = 1'b0;
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = '0;
        pcsrc      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                // IR and PC load only in the cycle the fetch completes.
                irwrite = mem_ready;
                pcwrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
                else if (op == OP_RTYP)         state_d = S_EXECUTE;
                else if (op == OP_BEQ)          state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                else if (op == OP_BNE)          state_d = S_BRANCH;
`endif
                else if (op == OP_ADDI)         state_d = S_ADDIEX;
                else if (op == OP_J)            state_d = S_JUMP;
                else begin
                    illegal_op = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                ret_inc  = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
                ret_inc  = mem_ready;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_W'(2'b10);
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                ret_inc  = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_W'(2'b01);
                pcsrc   = 2'b01;
                branch  = 1'b1;
                ret_inc = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                ret_inc  = 1'b1;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                ret_inc = 1'b1;
            end
            default: begin
                // Unused codes recover to FETCH silently and are not counted.
                state_d = S_FETCH;
            end
        endcase
        // Nothing may write or request while reset is held.
        if (!reset_n) begin
            mem_req    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            pcwrite    = 1'b0;
            regwrite   = 1'b0;
            branch     = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state = state_q;
`ifdef MC_CTRL_BNE_EN
    assign branch_ne = bne_q & (state_q == S_BRANCH);
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic       mr;
        int         st;
        outs_t      o;
        int         ret;
    } vec_t;

    localparam outs_t O_FETCH0 = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam outs_t O_FETCH1 = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam outs_t O_RSTF   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam outs_t O_DECODE = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam outs_t O_ILL    = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1};
    localparam outs_t O_MEMADR = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam outs_t O_MEMRD  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam outs_t O_MEMWB  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0};
    localparam outs_t O_MEMWR  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam outs_t O_EXEC   = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0};
    localparam outs_t O_ALUWB  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b1,1'b0};
    localparam outs_t O_BR     = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0,1'b0,1'b0};
    localparam outs_t O_ADDIWB = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0};
    localparam outs_t O_JUMP   = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0};

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       regdst, memtoreg, regwrite, illegal_op;
    logic [3:0] state;
    logic [3:0] retired;
`ifdef MC_CTRL_BNE_EN
    logic       branch_ne;
`endif
    outs_t      got;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.OP_W(6), .ALUOP_W(2), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .pcsrc(pcsrc), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .illegal_op(illegal_op),
`ifdef MC_CTRL_BNE_EN
        .branch_ne(branch_ne),
`endif
        .state(state), .retired(retired)
    );

    assign got = {mem_req, iord, memwrite, irwrite, pcwrite, branch, alusrca,
                  alusrcb, aluop, pcsrc, regdst, memtoreg, regwrite, illegal_op};

    task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, g, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [5:0] o, input logic m);
        reset_n   = r;
        op        = o;
        mem_ready = m;
        #1;
    endtask

    function automatic vec_t v(input logic r, input logic [5:0] o, input logic m,
                               input int st, input outs_t ex, input int ret);
        vec_t t;
        t.rst_n = r; t.op = o; t.mr = m; t.st = st; t.o = ex; t.ret = ret;
        return t;
    endfunction

    // Reference model: an instruction is the ordered list of states it visits.
    function automatic void build_seq(input logic [5:0] o, output int s[6], output int len,
                                      output bit ill);
        s = '{0, 1, 0, 0, 0, 0};
        ill = 0;
        case (o)
            6'b100011: begin s[2] = 2; s[3] = 3; s[4] = 4; len = 5; end
            6'b101011: begin s[2] = 2; s[3] = 5; len = 4; end
            6'b000000: begin s[2] = 6; s[3] = 7; len = 4; end
            6'b000100: begin s[2] = 8; len = 3; end
`ifdef MC_CTRL_BNE_EN
            6'b000101: begin s[2] = 8; len = 3; end
`endif
            6'b001000: begin s[2] = 9; s[3] = 10; len = 4; end
            6'b000010: begin s[2] = 11; len = 3; end
            default:   begin len = 2; ill = 1; end
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [8];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000101, 6'h00};
        ops[7] = 6'($urandom);
        return ops[$urandom_range(0, 7)];
    endfunction

    initial begin
        vec_t  tv[$];
        outs_t st_out[16];
        int    seq[6];
        int    len, idx, mret, est;
        bit    ill;
        outs_t eo;
        logic  r, m;
        logic [5:0] cur_op;

        // Directed vectors: reset, R-type, fetch stall + LW with MEMRD stall, illegal, SW, BEQ, ADDI, J, mid-instruction reset.
        tv.push_back(v(0, 6'b000000, 1, 0,  O_RSTF,   0));
        tv.push_back(v(0, 6'b000000, 1, 0,  O_RSTF,   0));
        tv.push_back(v(1, 6'b000000, 1, 0,  O_FETCH1, 0));
        tv.push_back(v(1, 6'b000000, 1, 1,  O_DECODE, 0));
        tv.push_back(v(1, 6'b000000, 1, 6,  O_EXEC,   0));
        tv.push_back(v(1, 6'b000000, 1, 7,  O_ALUWB,  0));
        tv.push_back(v(1, 6'b100011, 0, 0,  O_FETCH0, 1));
        tv.push_back(v(1, 6'b100011, 0, 0,  O_FETCH0, 1));
        tv.push_back(v(1, 6'b100011, 1, 0,  O_FETCH1, 1));
        tv.push_back(v(1, 6'b100011, 1, 1,  O_DECODE, 1));
        tv.push_back(v(1, 6'b100011, 1, 2,  O_MEMADR, 1));
        tv.push_back(v(1, 6'b100011, 0, 3,  O_MEMRD,  1));
        tv.push_back(v(1, 6'b100011, 0, 3,  O_MEMRD,  1));
        tv.push_back(v(1, 6'b100011, 0, 3,  O_MEMRD,  1));
        tv.push_back(v(1, 6'b100011, 1, 3,  O_MEMRD,  1));
        tv.push_back(v(1, 6'b100011, 1, 4,  O_MEMWB,  1));
        tv.push_back(v(1, 6'b111111, 1, 0,  O_FETCH1, 2));
        tv.push_back(v(1, 6'b111111, 1, 1,  O_ILL,    2));
        tv.push_back(v(1, 6'b101011, 1, 0,  O_FETCH1, 2));
        tv.push_back(v(1, 6'b101011, 1, 1,  O_DECODE, 2));
        tv.push_back(v(1, 6'b101011, 1, 2,  O_MEMADR, 2));
        tv.push_back(v(1, 6'b101011, 1, 5,  O_MEMWR,  2));
        tv.push_back(v(1, 6'b000100, 1, 0,  O_FETCH1, 3));
        tv.push_back(v(1, 6'b000100, 1, 1,  O_DECODE, 3));
        tv.push_back(v(1, 6'b000100, 1, 8,  O_BR,     3));
        tv.push_back(v(1, 6'b001000, 1, 0,  O_FETCH1, 4));
        tv.push_back(v(1, 6'b001000, 1, 1,  O_DECODE, 4));
        tv.push_back(v(1, 6'b001000, 1, 9,  O_MEMADR, 4));
        tv.push_back(v(1, 6'b001000, 1, 10, O_ADDIWB, 4));
        tv.push_back(v(1, 6'b000010, 1, 0,  O_FETCH1, 5));
        tv.push_back(v(1, 6'b000010, 1, 1,  O_DECODE, 5));
        tv.push_back(v(1, 6'b000010, 1, 11, O_JUMP,   5));
        tv.push_back(v(1, 6'b000000, 1, 0,  O_FETCH1, 6));
        tv.push_back(v(1, 6'b000000, 1, 1,  O_DECODE, 6));
        tv.push_back(v(0, 6'b000000, 1, 6,  O_EXEC,   6));
        tv.push_back(v(1, 6'b000000, 1, 0,  O_FETCH1, 0));

        drive(0, 6'b000000, 1);
        step();
        foreach (tv[i]) begin
            drive(tv[i].rst_n, tv[i].op, tv[i].mr);
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(tv[i].st));
            chk($sformatf("vec%0d_outs", i), 32'(got), 32'(tv[i].o));
            chk($sformatf("vec%0d_retired", i), 32'(retired), 32'(tv[i].ret));
            step();
        end

        // Back-to-back jumps: counter walks 0..15 then wraps to 0.
        drive(0, 6'b000010, 1);
        step();
        for (int k = 0; k < 16; k++) begin
            drive(1, 6'b000010, 1);
            chk($sformatf("jmp%0d_fetch", k), 32'(state), 0);
            chk($sformatf("jmp%0d_ret", k), 32'(retired), 32'(k));
            step();
            chk($sformatf("jmp%0d_decode", k), 32'(state), 1);
            step();
            chk($sformatf("jmp%0d_jstate", k), 32'(state), 11);
            chk($sformatf("jmp%0d_jouts", k), 32'(got), 32'(O_JUMP));
            step();
        end
        chk("jmp_wrap_state", 32'(state), 0);
        chk("jmp_wrap_ret", 32'(retired), 0);

        // Randomized run against the instruction-level model.
        st_out = '{default: '0};
        st_out[1] = O_DECODE; st_out[2] = O_MEMADR; st_out[3] = O_MEMRD;
        st_out[4] = O_MEMWB;  st_out[5] = O_MEMWR;  st_out[6] = O_EXEC;
        st_out[7] = O_ALUWB;  st_out[8] = O_BR;     st_out[9] = O_MEMADR;
        st_out[10] = O_ADDIWB; st_out[11] = O_JUMP;
        drive(0, 6'b000000, 1);
        step();
        mret = 0;
        idx = 0;
        cur_op = pick_op();
        build_seq(cur_op, seq, len, ill);
        for (int c = 0; c < 4000; c++) begin
            r = ($urandom_range(0, 59) != 0);
            m = ($urandom_range(0, 2) != 0);
            drive(r, cur_op, m);
            est = seq[idx];
            eo = (est == 0) ? (m ? O_FETCH1 : O_FETCH0) : st_out[est];
            if (est == 1 && ill) eo.illegal_op = 1'b1;
            if (!r) begin
                eo.mem_req = 0; eo.memwrite = 0; eo.irwrite = 0; eo.pcwrite = 0;
                eo.regwrite = 0; eo.branch = 0; eo.illegal_op = 0;
            end
            chk("rnd_state", 32'(state), 32'(est));
            chk("rnd_outs", 32'(got), 32'(eo));
            chk("rnd_retired", 32'(retired), 32'(mret));
`ifdef MC_CTRL_BNE_EN
            chk("rnd_branch_ne", 32'(branch_ne), 32'(est == 8 && cur_op == 6'b000101));
`endif
            step();
            if (!r) begin
                mret = 0;
                idx = 0;
                cur_op = pick_op();
                build_seq(cur_op, seq, len, ill);
            end else if ((est == 0 || est == 3 || est == 5) && !m) begin
                // memory access still pending
            end else begin
                idx++;
                if (idx == len) begin
                    if (!ill) mret = (mret + 1) % 16;
                    idx = 0;
                    cur_op = pick_op();
                    build_seq(cur_op, seq, len, ill);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
